// File: rtl/bypass_buff_mp_pkg.sv
// rtl/bypass_buff_mp_pkg.sv - shared defaults and helpers for the write-back bypass buffer
package bypass_buff_mp_pkg;

  localparam int DEF_BUFF_SIZE  = 8;
  localparam int DEF_NUM_SRC    = 3;
  localparam int DEF_WIDTH_DATA = 32;
  localparam int DEF_WIDTH_IDX  = 8;

  // Ring pointers carry one wrap bit above the slot index so full and empty differ.
  function automatic int ptr_width(input int buff_size);
    return $clog2(buff_size) + 1;
  endfunction

endpackage

// File: rtl/bypass_ring_ctrl.sv
// rtl/bypass_ring_ctrl.sv - write/read pointers, occupancy and head management of the bypass ring
module bypass_ring_ctrl
  import bypass_buff_mp_pkg::*;
#(
  parameter int BUFF_SIZE = DEF_BUFF_SIZE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         clr,
  input  logic                         head_valid,
  output logic [$clog2(BUFF_SIZE)-1:0] wr_idx,
  output logic [$clog2(BUFF_SIZE)-1:0] rd_idx,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(BUFF_SIZE):0]   num
);

  localparam int PW = ptr_width(BUFF_SIZE);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    num      = wr_ptr_q - rd_ptr_q;
    full     = (num == PW'(BUFF_SIZE));
    empty    = (num == '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    // Clr keeps only a same-cycle write; otherwise overwrite-when-full and hole reclaim share one step.
    if (clr) rd_ptr_d = wr_ptr_q;
    else if ((wr_en && full) || (!empty && !head_valid)) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_idx = wr_ptr_q[PW-2:0];
  assign rd_idx = rd_ptr_q[PW-2:0];

endmodule

// File: rtl/bypass_buff_mp.sv
// rtl/bypass_buff_mp.sv - multi-port write-back bypass buffer with youngest-match forwarding
module bypass_buff_mp
  import bypass_buff_mp_pkg::*;
#(
  parameter int BUFF_SIZE  = DEF_BUFF_SIZE,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int WIDTH_IDX  = DEF_WIDTH_IDX
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Stall,
  input  logic                            I_WB_Valid,
  input  logic [WIDTH_IDX-1:0]            I_WB_Index,
  input  logic [WIDTH_DATA-1:0]           I_WB_Data,
  input  logic [WIDTH_IDX-1:0]            I_Slice_Len,
  input  logic [NUM_SRC-1:0]              I_Src_Valid,
  input  logic [NUM_SRC*WIDTH_IDX-1:0]    I_Src_Index,
  input  logic [NUM_SRC*WIDTH_DATA-1:0]   I_Src_Data,
  output logic [NUM_SRC*WIDTH_DATA-1:0]   O_Src_Data,
  output logic [NUM_SRC-1:0]              O_Hit,
  output logic                            O_Full,
  output logic                            O_Empty,
  output logic [$clog2(BUFF_SIZE):0]      O_Num
);

  localparam int AW = $clog2(BUFF_SIZE);

  typedef struct packed {
    logic                  v;
    logic [WIDTH_IDX-1:0]  idx;
    logic [WIDTH_DATA-1:0] data;
  } bypass_entry_t;

  bypass_entry_t        buff_q [BUFF_SIZE];
  bypass_entry_t        buff_d [BUFF_SIZE];
  logic [NUM_SRC-1:0]   run_q, run_d;
  logic [WIDTH_IDX-1:0] end_q [NUM_SRC];
  logic [WIDTH_IDX-1:0] end_d [NUM_SRC];

  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 scalar, clr, head_valid;
  logic [NUM_SRC-1:0]   fwd, buf_hit, settled;
  logic [AW-1:0]        sel_idx [NUM_SRC];

  assign scalar     = (I_Slice_Len == '0);
  assign head_valid = buff_q[rd_idx].v;
  assign clr        = !scalar && !I_Stall && (&settled);

  bypass_ring_ctrl #(.BUFF_SIZE(BUFF_SIZE)) u_ring (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (I_WB_Valid),
    .clr        (clr),
    .head_valid (head_valid),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .full       (O_Full),
    .empty      (O_Empty),
    .num        (O_Num)
  );

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [WIDTH_IDX-1:0]  idx;
    logic [BUFF_SIZE-1:0]  match, rot;
    logic                  hit;
    logic [AW-1:0]         sel;
    logic [WIDTH_DATA-1:0] data;

    assign idx        = I_Src_Index[k*WIDTH_IDX +: WIDTH_IDX];
    assign fwd[k]     = I_Src_Valid[k] && I_WB_Valid && (I_WB_Index == idx);
    assign settled[k] = run_q[k] ? (I_Src_Valid[k] && (idx == end_q[k])) : !I_Src_Valid[k];

    // Rotating by Wr_Ptr puts the youngest slot at the top bit, so the last set bit wins.
    always_comb begin
      match = '0;
      rot   = '0;
      hit   = 1'b0;
      sel   = '0;
      for (int i = 0; i < BUFF_SIZE; i++)
        match[i] = I_Src_Valid[k] && buff_q[i].v && (buff_q[i].idx == idx);
      for (int j = 0; j < BUFF_SIZE; j++)
        rot[j] = match[AW'(wr_idx + AW'(j))];
      for (int j = 0; j < BUFF_SIZE; j++) begin
        if (rot[j]) begin
          hit = 1'b1;
          sel = AW'(wr_idx + AW'(j));
        end
      end
    end

    always_comb begin
      data = I_Src_Data[k*WIDTH_DATA +: WIDTH_DATA];
      if (!I_Stall) begin
        if (fwd[k]) data = I_WB_Data;
        else if (hit) data = buff_q[sel].data;
      end
    end

    assign buf_hit[k] = hit;
    assign sel_idx[k] = sel;
    assign O_Hit[k]   = !I_Stall && (fwd[k] || hit);
    assign O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = data;
  end

  always_comb begin
    run_d = run_q;
    end_d = end_q;
    if (!scalar && !I_Stall) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!run_q[k]) begin
          if (I_Src_Valid[k]) begin
            run_d[k] = 1'b1;
            end_d[k] = I_Src_Index[k*WIDTH_IDX +: WIDTH_IDX] + I_Slice_Len;
          end
        end else if (settled[k]) begin
          run_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    buff_d = buff_q;
    if (clr) begin
      for (int i = 0; i < BUFF_SIZE; i++) buff_d[i].v = 1'b0;
    end
    if (scalar && !I_Stall) begin
      for (int k = 0; k < NUM_SRC; k++)
        if (buf_hit[k] && !fwd[k]) buff_d[sel_idx[k]].v = 1'b0;
    end
    // A scalar same-cycle forward consumes the value, so it lands as a hole.
    if (I_WB_Valid) begin
      buff_d[wr_idx].v    = !(scalar && !I_Stall && (|fwd));
      buff_d[wr_idx].idx  = I_WB_Index;
      buff_d[wr_idx].data = I_WB_Data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= '0;
      for (int k = 0; k < NUM_SRC; k++) end_q[k] <= '0;
      for (int i = 0; i < BUFF_SIZE; i++) buff_q[i] <= '0;
    end else begin
      run_q  <= run_d;
      end_q  <= end_d;
      buff_q <= buff_d;
    end
  end

endmodule
